// File: rtl/fft_pkg.sv
// Shared FFT definitions for the index generator, mapper and butterfly controller.
//   fft_state_e : sequencer state encoding (IDLE, RUN, GAP, DONE)
//   GAP_W       : width of the inter-stage dead-time counter (covers 0..255)
//   clog2       : ceiling log2, elaboration-time helper
//   num_points  : N = 2^msb
//   stage_w     : stage bus width, nominally msb/2, widened where msb/2 bits cannot hold msb
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } fft_state_e;

    localparam int unsigned GAP_W = 8;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
        end
        return r;
    endfunction

    function automatic int unsigned num_points(input int unsigned msb);
        return 32'(1) << msb;
    endfunction

    // msb/2 bits hold msb for msb >= 6; msb = 4 needs 3 bits to represent stage 4.
    function automatic int unsigned stage_w(input int unsigned msb);
        int unsigned half;
        int unsigned need;
        half = msb / 2;
        need = clog2(msb + 1);
        return (half > need) ? half : need;
    endfunction

endpackage

// File: rtl/fft_index_gen.sv
// FFT index sequencer: on start, walks stages 1..MSB and indices 0..N-1 per stage,
// presenting (index, stage) pairs under a valid/ready handshake, with an optional
// STAGE_GAP-cycle dead time between stages for the butterfly pipeline to drain.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   start, abort        : begin a pass (IDLE only) / synchronous cancel to IDLE
//   idx_valid, idx_ready: output handshake
//   index_out, stage_out: current pair; stage_out reads 0 when idle
//   last_in_stage, last : index N-1 / final pair markers, qualified by idx_valid
//   busy, done          : pass in progress (RUN/GAP) / one-cycle completion pulse
module fft_index_gen
    import fft_pkg::*;
#(
    parameter int unsigned MSB       = 8,
    parameter int unsigned STAGE_GAP = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          abort,
    output logic                          idx_valid,
    input  logic                          idx_ready,
    output logic [MSB-1:0]                index_out,
    output logic [stage_w(MSB)-1:0]       stage_out,
    output logic                          last_in_stage,
    output logic                          last,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned N  = num_points(MSB);
    localparam int unsigned SW = stage_w(MSB);

    localparam logic [MSB-1:0]   IDX_LAST  = MSB'(N - 1);
    localparam logic [SW-1:0]    STG_LAST  = SW'(MSB);
    localparam logic [SW-1:0]    STG_FIRST = SW'(1);
    localparam logic [GAP_W-1:0] GAP_INIT  = GAP_W'(STAGE_GAP - 1);

    // Elaboration guard on parameter ranges.
    if (MSB < 4 || MSB > 16 || (MSB % 2) != 0) begin : g_bad_msb
        $error("fft_index_gen: MSB must be even and in 4..16");
    end
    if (STAGE_GAP > 255) begin : g_bad_gap
        $error("fft_index_gen: STAGE_GAP must be in 0..255");
    end

    fft_state_e       state_q, state_d;
    logic [MSB-1:0]   index_d;
    logic [SW-1:0]    stage_d;
    logic [GAP_W-1:0] cnt_q, cnt_d;
    logic             valid_d, busy_d, done_d, lis_d, last_d;
    logic             hs;

    // idx_valid is a register, so idx_ready only feeds next-state logic.
    assign hs = idx_valid && idx_ready;

    // Next-state, next-counter and next-output decode.
    always_comb begin
        state_d = state_q;
        index_d = index_out;
        stage_d = stage_out;
        cnt_d   = cnt_q;

        if (abort) begin
            state_d = ST_IDLE;
            index_d = '0;
            stage_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    index_d = '0;
                    stage_d = '0;
                    if (start) begin
                        state_d = ST_RUN;
                        stage_d = STG_FIRST;
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        if (index_out != IDX_LAST) begin
                            index_d = MSB'(index_out + MSB'(1));
                        end else if (stage_out == STG_LAST) begin
                            state_d = ST_DONE;
                        end else if (STAGE_GAP == 0) begin
                            index_d = '0;
                            stage_d = SW'(stage_out + SW'(1));
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = GAP_INIT;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                        index_d = '0;
                        stage_d = SW'(stage_out + SW'(1));
                    end else begin
                        cnt_d = GAP_W'(cnt_q - GAP_W'(1));
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    index_d = '0;
                    stage_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    index_d = '0;
                    stage_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_RUN) || (state_d == ST_GAP);
        done_d  = (state_d == ST_DONE);
        lis_d   = valid_d && (index_d == IDX_LAST);
        last_d  = lis_d && (stage_d == STG_LAST);
    end

    // State and gap counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index_out     <= '0;
            stage_out     <= '0;
            idx_valid     <= 1'b0;
            last_in_stage <= 1'b0;
            last          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            index_out     <= index_d;
            stage_out     <= stage_d;
            idx_valid     <= valid_d;
            last_in_stage <= lis_d;
            last          <= last_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

endmodule

// File: tb/tb_fft_index_gen.sv
// Self-checking bench for fft_index_gen: two instances (MSB=4, STAGE_GAP=2 and 0),
// scenario table plus hand-written abort and mid-gap reset sequences.
module tb_fft_index_gen;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       idx_ready;
    logic       sel;

    logic       a_start, a_valid, a_lis, a_last, a_busy, a_done;
    logic [3:0] a_index;
    logic [2:0] a_stage;
    logic       b_start, b_valid, b_lis, b_last, b_busy, b_done;
    logic [3:0] b_index;
    logic [2:0] b_stage;

    logic       o_valid, o_lis, o_last, o_busy, o_done;
    logic [3:0] o_index;
    logic [2:0] o_stage;

    assign a_start = start & ~sel;
    assign b_start = start & sel;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_lis   = sel ? b_lis   : a_lis;
    assign o_last  = sel ? b_last  : a_last;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;
    assign o_index = sel ? b_index : a_index;
    assign o_stage = sel ? b_stage : a_stage;

    fft_index_gen #(.MSB(4), .STAGE_GAP(2)) u_gap2 (
        .clk(clk), .reset_n(reset_n), .start(a_start), .abort(abort),
        .idx_valid(a_valid), .idx_ready(idx_ready), .index_out(a_index),
        .stage_out(a_stage), .last_in_stage(a_lis), .last(a_last),
        .busy(a_busy), .done(a_done)
    );

    fft_index_gen #(.MSB(4), .STAGE_GAP(0)) u_gap0 (
        .clk(clk), .reset_n(reset_n), .start(b_start), .abort(abort),
        .idx_valid(b_valid), .idx_ready(idx_ready), .index_out(b_index),
        .stage_out(b_stage), .last_in_stage(b_lis), .last(b_last),
        .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sel;       // 0: STAGE_GAP=2 instance, 1: STAGE_GAP=0 instance
        int mode;      // 0: idx_ready held high, 1: pseudo-random ready
        int restart;   // re-pulse start at stage 2 index 7
        int exp_last;  // cycle of final handshake, -1 = not checked
        int exp_done;  // cycle of done pulse, -1 = not checked
        int exp_gap;   // total busy-but-invalid cycles
    } scen_t;

    typedef struct packed {
        logic [3:0] idx;
        logic [2:0] stg;
        logic       lis;
        logic       last;
    } exp_t;

    exp_t  sb[$];
    int    tests;
    int    fails;
    int    cyc;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Reference order of pairs for one full MSB=4 pass.
    task automatic load_model();
        exp_t e;
        sb.delete();
        for (int s = 1; s <= 4; s++) begin
            for (int i = 0; i < 16; i++) begin
                e.idx  = 4'(i);
                e.stg  = 3'(s);
                e.lis  = (i == 15);
                e.last = (i == 15) && (s == 4);
                sb.push_back(e);
            end
        end
    endtask

    function automatic int idle_word();
        return int'({o_valid, o_busy, o_done, o_lis, o_last, o_stage, o_index});
    endfunction

    task automatic run_pass(input scen_t sc);
        int   hs_n, lis_n, last_n, gap_n, last_cyc, done_cyc;
        bit   restarted, stalled;
        int   saved;
        exp_t e;
        sel       = sc.sel[0];
        load_model();
        hs_n      = 0; lis_n = 0; last_n = 0; gap_n = 0;
        last_cyc  = -1; done_cyc = -1;
        restarted = 1'b0; stalled = 1'b0; saved = 0;
        idx_ready = 1'b1;
        start     = 1'b1;
        cyc       = 0;
        step();
        start = 1'b0;
        check("first_valid", int'(o_valid), 1);
        while (done_cyc < 0 && cyc < 600) begin
            idx_ready = (sc.mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            start = 1'b0;
            if (sc.restart != 0 && !restarted && o_valid && o_stage == 3'd2 && o_index == 4'd7) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (stalled)
                check("stall_hold", int'({o_valid, o_index, o_stage, o_lis, o_last}), saved);
            if (o_valid && idx_ready) begin
                if (sb.size() == 0) begin
                    check("extra_pair", int'({o_index, o_stage}), 0);
                end else begin
                    e = sb.pop_front();
                    check("pair", int'({o_index, o_stage, o_lis, o_last}), int'(e));
                end
                hs_n++;
                if (o_lis)  lis_n++;
                if (o_last) last_n++;
                last_cyc = cyc;
            end
            stalled = o_valid && !idx_ready;
            saved   = int'({o_valid, o_index, o_stage, o_lis, o_last});
            if (o_busy && !o_valid) begin
                gap_n++;
                check("gap_index", int'(o_index), 15);
            end
            if (o_done) done_cyc = cyc;
            else step();
        end
        start = 1'b0;
        check("pass_finished", int'(done_cyc >= 0), 1);
        check("handshakes", hs_n, 64);
        check("last_in_stage_count", lis_n, 4);
        check("last_count", last_n, 1);
        check("queue_empty", sb.size(), 0);
        check("gap_cycles", gap_n, sc.exp_gap);
        check("done_not_busy", int'(o_busy), 0);
        if (sc.exp_last >= 0) check("last_hs_cycle", last_cyc, sc.exp_last);
        if (sc.exp_done >= 0) check("done_cycle", done_cyc, sc.exp_done);
        step();
        check("idle_after_done", idle_word(), 0);
        step();
        check("idle_hold", idle_word(), 0);
    endtask

    scen_t tbl[5];

    initial begin
        bit   found;
        int   bad;
        tests = 0; fails = 0; cyc = 0;
        tbl[0] = '{sel: 0, mode: 0, restart: 0, exp_last: 70, exp_done: 71, exp_gap: 6};
        tbl[1] = '{sel: 0, mode: 1, restart: 0, exp_last: -1, exp_done: -1, exp_gap: 6};
        tbl[2] = '{sel: 1, mode: 0, restart: 0, exp_last: 64, exp_done: 65, exp_gap: 0};
        tbl[3] = '{sel: 0, mode: 0, restart: 1, exp_last: 70, exp_done: 71, exp_gap: 6};
        tbl[4] = '{sel: 1, mode: 1, restart: 0, exp_last: -1, exp_done: -1, exp_gap: 0};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; idx_ready = 1'b0; sel = 1'b0;
        #1;
        check("reset_gap2", int'({a_valid, a_busy, a_done, a_lis, a_last, a_stage, a_index}), 0);
        check("reset_gap0", int'({b_valid, b_busy, b_done, b_lis, b_last, b_stage, b_index}), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("idle_after_reset", idle_word(), 0);

        for (int t = 0; t < 5; t++) run_pass(tbl[t]);

        // Abort at stage 3 index 5 together with an accepting ready.
        sel = 1'b0; idx_ready = 1'b1; start = 1'b1; cyc = 0;
        step();
        start = 1'b0;
        found = 1'b0;
        while (!found && cyc < 200) begin
            if (o_valid && o_stage == 3'd3 && o_index == 4'd5) found = 1'b1;
            else step();
        end
        check("abort_point_reached", int'(found), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle", idle_word(), 0);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (o_done || o_valid || o_busy) bad++;
        end
        check("abort_no_done", bad, 0);
        run_pass(tbl[0]);

        // Asynchronous reset in the first inter-stage gap.
        sel = 1'b0; idx_ready = 1'b1; start = 1'b1; cyc = 0;
        step();
        start = 1'b0;
        found = 1'b0;
        while (!found && cyc < 200) begin
            if (o_busy && !o_valid) found = 1'b1;
            else step();
        end
        check("gap_reached", int'(found), 1);
        check("gap_entry_cycle", cyc, 17);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", idle_word(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("idle_after_async_reset", idle_word(), 0);
        run_pass(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
